// File: rtl/fir_pkg.sv
// Shared definitions for the FIR controller: register map, sequencer states
// and the rounding/saturating output conversion.
package fir_pkg;

  localparam int FIR_NTAPS = 16;
  localparam int FIR_DW    = 16;
  localparam int FIR_ACCW  = 36;

  localparam logic [5:0] ADDR_CTRL      = 6'h00;
  localparam logic [5:0] ADDR_STATUS    = 6'h01;
  localparam logic [5:0] ADDR_DIN       = 6'h02;
  localparam logic [5:0] ADDR_DOUT      = 6'h03;
  localparam logic [5:0] ADDR_TAPS      = 6'h04;
  localparam logic [5:0] ADDR_COEF_BASE = 6'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_SAT  = 2'd2
  } state_t;

  localparam logic signed [FIR_ACCW-1:0] RND_HALF = FIR_ACCW'(1) <<< (FIR_DW - 2);
  localparam logic signed [FIR_ACCW-1:0] SAT_MAX  = FIR_ACCW'((1 << (FIR_DW - 1)) - 1);
  localparam logic signed [FIR_ACCW-1:0] SAT_MIN  = -SAT_MAX - 1;

  // Round-half-up from Q2.30-scaled accumulator back to Q1.15, then clamp.
  function automatic logic [FIR_DW-1:0] sat16(input logic signed [FIR_ACCW-1:0] acc);
    logic signed [FIR_ACCW-1:0] q;
    logic [FIR_DW-1:0]          res;
    q = (acc + RND_HALF) >>> (FIR_DW - 1);
    if (q > SAT_MAX)      res = SAT_MAX[FIR_DW-1:0];
    else if (q < SAT_MIN) res = SAT_MIN[FIR_DW-1:0];
    else                  res = q[FIR_DW-1:0];
    return res;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath: signed DW x DW product summed into an ACCW-bit
// accumulator. clr has priority so every computation starts from zero.
module fir_mac #(
  parameter int DW   = 16,
  parameter int ACCW = 36
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = a * b;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement or process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + {{(ACCW - 2*DW){prod[2*DW-1]}}, prod};
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// FIR register bank and tap sequencer: holds coefficients, sample history and
// config, runs one MAC per tap through fir_mac, and reports a saturated result.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int NTAPS_MAX = FIR_NTAPS,
  parameter int DW        = FIR_DW,
  parameter int ACCW      = FIR_ACCW
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [5:0]  p_address,
  input  logic [15:0] p_data,
  input  logic        p_wr,
  output logic [15:0] p_data_back,
  output logic        irq
);

  localparam int IW = $clog2(NTAPS_MAX);

  state_t state, state_nxt;

  logic                   ie, done, ovr;
  logic [3:0]             taps, k;
  logic [IW-1:0]          k_idx;
  logic [DW-1:0]          dout;
  logic [DW-1:0]          coef [NTAPS_MAX];
  logic [DW-1:0]          hist [NTAPS_MAX];
  logic signed [ACCW-1:0] acc;

  logic busy, start, mac_en, sat_en;
  logic wr_ctrl, wr_status, wr_din, wr_taps, wr_coef, clr, collide;

  assign wr_ctrl   = p_wr && (p_address == ADDR_CTRL);
  assign wr_status = p_wr && (p_address == ADDR_STATUS);
  assign wr_din    = p_wr && (p_address == ADDR_DIN);
  assign wr_taps   = p_wr && (p_address == ADDR_TAPS);
  assign wr_coef   = p_wr && (p_address[5:4] == ADDR_COEF_BASE[5:4]);
  assign clr       = wr_ctrl && p_data[1];

  assign busy    = (state != ST_IDLE);
  assign collide = busy && (wr_din || wr_taps || wr_coef);
  assign k_idx   = k[IW-1:0];
  assign irq     = done && ie;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    mac_en    = 1'b0;
    sat_en    = 1'b0;
    case (state)
      ST_IDLE: if (wr_din) begin
        start     = 1'b1;
        state_nxt = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (k == taps) state_nxt = ST_SAT;
      end
      ST_SAT: begin
        sat_en    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // CLR aborts whatever is in flight; DOUT and DONE keep their old values.
    if (clr) begin
      state_nxt = ST_IDLE;
      start     = 1'b0;
      mac_en    = 1'b0;
      sat_en    = 1'b0;
    end
  end

  // NOTE: coefficient and history arrays are small flop banks that must read
  // back zero after reset, so they are reset like any other register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ie   <= 1'b0;
      done <= 1'b0;
      ovr  <= 1'b0;
      taps <= '0;
      k    <= '0;
      dout <= '0;
      for (int i = 0; i < NTAPS_MAX; i++) begin
        coef[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      if (wr_ctrl) ie <= p_data[0];

      if (sat_en)                       done <= 1'b1;
      else if (wr_status && p_data[1])  done <= 1'b0;

      if (collide)                      ovr <= 1'b1;
      else if (wr_status && p_data[2])  ovr <= 1'b0;

      if (wr_taps && !busy) taps <= p_data[3:0];
      if (wr_coef && !busy) coef[p_address[IW-1:0]] <= p_data;

      if (clr) begin
        for (int i = 0; i < NTAPS_MAX; i++) hist[i] <= '0;
      end else if (start) begin
        for (int i = NTAPS_MAX - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= p_data;
      end

      if (start)       k <= '0;
      else if (mac_en) k <= k + 4'd1;

      if (sat_en) dout <= sat16(acc);
    end
  end

  fir_mac #(.DW(DW), .ACCW(ACCW)) u_mac (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (start),
    .en    (mac_en),
    .a     (coef[k_idx]),
    .b     (hist[k_idx]),
    .acc   (acc)
  );

  always_comb begin
    p_data_back = '0;
    case (p_address)
      ADDR_CTRL:   p_data_back = {15'b0, ie};
      ADDR_STATUS: p_data_back = {13'b0, ovr, done, busy};
      ADDR_DIN:    p_data_back = hist[0];
      ADDR_DOUT:   p_data_back = dout;
      ADDR_TAPS:   p_data_back = {12'b0, taps};
      default: if (p_address[5:4] == ADDR_COEF_BASE[5:4]) p_data_back = coef[p_address[IW-1:0]];
    endcase
  end

endmodule
